// File: rtl/pipelined_adder.sv
// Carry-skewed pipelined adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, valid/ready handshake with a single global stall.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    // Stage s registers hold the operation after slice s has been added.
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] bp_q    [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q;

    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] bp_d    [STAGES];
    logic [WIDTH-1:0] res_in  [STAGES];
    logic             cin_d   [STAGES];
    logic [WIDTH-1:0] res_d   [STAGES];
    logic             carry_d [STAGES];
    logic             ovf_d;
    logic             advance;

    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}}) << (gi * CHUNK);
            logic [CHUNK:0] slice_sum;

            if (gi == 0) begin : g_first
                // Subtraction is a + ~b + 1, so cin is replaced by 1 in that mode.
                assign valid_d[gi] = in_valid;
                assign a_d[gi]     = a;
                assign bp_d[gi]    = sub ? ~b : b;
                assign res_in[gi]  = '0;
                assign cin_d[gi]   = sub ? 1'b1 : cin;
            end else begin : g_next
                assign valid_d[gi] = valid_q[gi-1];
                assign a_d[gi]     = a_q[gi-1];
                assign bp_d[gi]    = bp_q[gi-1];
                assign res_in[gi]  = res_q[gi-1];
                assign cin_d[gi]   = carry_q[gi-1];
            end

            assign slice_sum = {1'b0, a_d[gi][gi*CHUNK +: CHUNK]}
                             + {1'b0, bp_d[gi][gi*CHUNK +: CHUNK]}
                             + {{CHUNK{1'b0}}, cin_d[gi]};
            assign res_d[gi]   = (res_in[gi] & ~SLICE_MASK)
                               | (WIDTH'(slice_sum[CHUNK-1:0]) << (gi * CHUNK));
            assign carry_d[gi] = slice_sum[CHUNK];
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b' ^ s.
    assign ovf_d = a_d[STAGES-1][WIDTH-1] ^ bp_d[STAGES-1][WIDTH-1]
                 ^ res_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                res_q[s]   <= '0;
                carry_q[s] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                a_q[s]     <= a_d[s];
                bp_q[s]    <= bp_d[s];
                res_q[s]   <= res_d[s];
                carry_q[s] <= carry_d[s];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed table, stalled random stream against an
// arithmetic reference model, mid-flight reset, and an exhaustive 1-stage config.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic       in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [3:0] a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(4), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range test for ovf.
    function automatic void model(input int w, input longint av, input longint bv,
                                  input bit c, input bit sb,
                                  output longint s, output bit co, output bit ov);
        longint m, half, sa, sbv, full, sres;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (av >= half) ? av - (m + 1) : av;
        sbv  = (bv >= half) ? bv - (m + 1) : bv;
        if (sb) begin
            full = av - bv;
            co   = (av >= bv);
            sres = sa - sbv;
        end else begin
            full = av + bv + longint'(c);
            co   = (full > m);
            sres = sa + sbv + longint'(c);
        end
        s  = full & m;
        ov = (sres >= half) || (sres < -half);
    endfunction

    vec_t   vecs[6];
    res_t   exp_q[$];
    res_t   r, held;
    bit     held_v, acc, cons, do_new;
    int     sent, got;
    longint ms;
    bit     mco, mov;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed vectors, one at a time, checking exact latency and a one-cycle pulse.
        for (int i = 0; i < 6; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            for (int e = 1; e < 4; e++) begin
                check($sformatf("vec%0d_latency_e%0d", i, e), 32'(out_valid), 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout_ovf", i), {30'd0, cout, ovf},
                  {30'd0, vecs[i].exp_cout, vecs[i].exp_ovf});
            $display("vec%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, sum, cout, ovf);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 32'(out_valid), 32'd0);
        end

        // Random stream with a stalling consumer.
        sent = 0; got = 0; held_v = 0; do_new = 1;
        for (int cyc = 0; cyc < 3000 && got < 128; cyc++) begin
            if (do_new) begin
                if (sent < 128) begin
                    a = 16'($urandom); b = 16'($urandom);
                    cin = 1'($urandom); sub = 1'($urandom);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom);
            #1;
            if (held_v) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_result", {15'd0, sum, cout},
                      {15'd0, held.s, held.co});
                check("stall_hold_ovf", 32'(ovf), 32'(held.ov));
            end
            held_v = out_valid && !out_ready;
            if (held_v) begin
                held = '{sum, cout, ovf};
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (acc) begin
                model(16, longint'(a), longint'(b), cin, sub, ms, mco, mov);
                exp_q.push_back('{16'(ms), mco, mov});
                sent++;
            end
            if (cons) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check($sformatf("stream%0d_sum", got), 32'(sum), 32'(r.s));
                    check($sformatf("stream%0d_cout_ovf", got), {30'd0, cout, ovf},
                          {30'd0, r.co, r.ov});
                    $display("stream%0d sum=%h cout=%0d ovf=%0d", got, sum, cout, ovf);
                end
                got++;
            end
            do_new = acc;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_count", got, 32'd128);
        check("stream_queue_empty", exp_q.size(), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stream_no_extra", 32'(out_valid), 32'd0);
        end

        // Mid-flight reset: three accepted ops plus one offered on the reset edge.
        for (int k = 0; k < 4; k++) begin
            a = 16'h1000 * 16'(k + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            if (k == 3) rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_nothing_emerges", 32'(out_valid), 32'd0);
        end
        $display("midrst done");

        // Single-stage config: exhaustive stream, each result one edge after acceptance.
        check("deg_idle", 32'(out_valid1), 32'd0);
        for (int i = 0; i <= 512; i++) begin
            if (i > 0) begin
                model(4, longint'(a1), longint'(b1), cin1, 1'b0, ms, mco, mov);
                check($sformatf("deg%0d", i - 1), {26'd0, out_valid1, sum1, cout1},
                      {26'd0, 1'b1, 4'(ms), mco});
            end
            if (i < 512) begin
                a1 = 4'(i >> 5); b1 = 4'(i >> 1); cin1 = 1'(i);
                in_valid1 = 1'b1;
            end else begin
                in_valid1 = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("deg_drained", 32'(out_valid1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
